// File: rtl/ex_cond_stage.sv
// ex_cond_stage: ARM condition check, NZCV flags register and EX/MEM pipeline register (optional squash counter via EX_COND_SQUASH_CNT_EN)
module ex_cond_stage #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RegWriteE,
  input  logic          MemtoRegE,
  input  logic          MemWriteE,
  input  logic          BranchE,
  input  logic [1:0]    FlagWriteE,
  input  logic [3:0]    CondE,
  input  logic [3:0]    ALUFlagsE,
  input  logic [DW-1:0] ALUResultE,
  input  logic [DW-1:0] WriteDataE,
  input  logic [AW-1:0] WA3E,
  input  logic          stallM,
  input  logic          flushM,
  output logic          CondExE,
  output logic          PCSrcE,
  output logic [3:0]    Flags,
  output logic          RegWriteM,
  output logic          MemtoRegM,
  output logic          MemWriteM,
  output logic [DW-1:0] ALUResultM,
  output logic [DW-1:0] WriteDataM,
  output logic [AW-1:0] WA3M
`ifdef EX_COND_SQUASH_CNT_EN
  ,output logic [31:0]  squash_cnt
`endif
);
  logic n, z, c, v;
  logic [15:0] cond_tbl;
  assign {n, z, c, v} = Flags;
  // condition results indexed by CondE; 1111 behaves as AL
  always_comb begin
    cond_tbl = {1'b1, 1'b1, z | (n != v), !z & (n == v), n != v, n == v, !c | z, c & !z,
                !v, v, !n, n, !c, c, !z, z};
    CondExE  = cond_tbl[CondE];
    PCSrcE   = BranchE & CondExE & !flushM;
  end
  // falling-edge EX/MEM register and flags: stall holds, flush kills, failed condition annuls writes
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      Flags      <= '0;
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      WA3M       <= '0;
    end else if (!stallM) begin
      if (flushM) begin
        RegWriteM  <= 1'b0;
        MemtoRegM  <= 1'b0;
        MemWriteM  <= 1'b0;
        ALUResultM <= '0;
        WriteDataM <= '0;
        WA3M       <= '0;
      end else begin
        RegWriteM  <= RegWriteE & CondExE;
        MemtoRegM  <= MemtoRegE;
        MemWriteM  <= MemWriteE & CondExE;
        ALUResultM <= ALUResultE;
        WriteDataM <= WriteDataE;
        WA3M       <= WA3E;
        Flags[3:2] <= (FlagWriteE[1] & CondExE) ? ALUFlagsE[3:2] : Flags[3:2];
        Flags[1:0] <= (FlagWriteE[0] & CondExE) ? ALUFlagsE[1:0] : Flags[1:0];
      end
    end
  end
`ifdef EX_COND_SQUASH_CNT_EN
  logic squash;
  assign squash = !stallM & !flushM & !CondExE & (RegWriteE | MemWriteE | BranchE | (|FlagWriteE));
  // counts annulled instructions that would have had a side effect; wraps naturally
  always_ff @(negedge clk or posedge rst) begin
    if (rst) squash_cnt <= '0;
    else if (squash) squash_cnt <= squash_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_ex_cond_stage.sv
// tb_ex_cond_stage: directed self-checking bench for ex_cond_stage
module tb_ex_cond_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic RegWriteE = 0, MemtoRegE = 0, MemWriteE = 0, BranchE = 0, stallM = 0, flushM = 0;
  logic [1:0] FlagWriteE = 0;
  logic [3:0] CondE = 0, ALUFlagsE = 0;
  logic [31:0] ALUResultE = 0, WriteDataE = 0;
  logic [3:0] WA3E = 0;
  logic CondExE, PCSrcE, RegWriteM, MemtoRegM, MemWriteM;
  logic [3:0] Flags, WA3M;
  logic [31:0] ALUResultM, WriteDataM;
`ifdef EX_COND_SQUASH_CNT_EN
  logic [31:0] squash_cnt;
`endif
  int tests = 0, fails = 0;

  ex_cond_stage #(.DW(32), .AW(4)) dut (
    .clk(clk), .rst(rst), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .FlagWriteE(FlagWriteE), .CondE(CondE), .ALUFlagsE(ALUFlagsE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E), .stallM(stallM), .flushM(flushM),
    .CondExE(CondExE), .PCSrcE(PCSrcE), .Flags(Flags), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M)
`ifdef EX_COND_SQUASH_CNT_EN
    , .squash_cnt(squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fall();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; BranchE = 0; FlagWriteE = 0;
    CondE = 4'hE; ALUFlagsE = 0; ALUResultE = 0; WriteDataE = 0; WA3E = 0;
  endtask

  initial begin
    #12;
    chk("rst_flags", {28'd0, Flags}, 0);
    chk("rst_regwr", {31'd0, RegWriteM}, 0);
    chk("rst_alu", ALUResultM, 0);
    rst = 0;
    idle();
    RegWriteE = 1; ALUResultE = 32'h2A; WA3E = 4; WriteDataE = 32'h11;
    #1 chk("al_condex", {31'd0, CondExE}, 1);
    fall();
    chk("s1_regwr", {31'd0, RegWriteM}, 1);
    chk("s1_alu", ALUResultM, 32'h2A);
    chk("s1_wa3", {28'd0, WA3M}, 4);
    chk("s1_wdata", WriteDataM, 32'h11);
    chk("s1_flags", {28'd0, Flags}, 0);
    idle(); FlagWriteE = 2'b11; ALUFlagsE = 4'b0100;
    fall();
    chk("z_flags", {28'd0, Flags}, 4'b0100);
    idle(); BranchE = 1; CondE = 4'b0000; ALUFlagsE = 4'b1111;
    #1 chk("eq_pcsrc", {31'd0, PCSrcE}, 1);
    CondE = 4'b0001;
    #1 chk("ne_pcsrc", {31'd0, PCSrcE}, 0);
    idle(); FlagWriteE = 2'b11; ALUFlagsE = 4'b1000;
    fall();
    chk("n_flags", {28'd0, Flags}, 4'b1000);
    idle(); MemWriteE = 1; MemtoRegE = 1; CondE = 4'b1010; WriteDataE = 32'hDEADBEEF;
    #1 chk("ge_condex", {31'd0, CondExE}, 0);
    CondE = 4'b1011;
    #1 chk("lt_condex", {31'd0, CondExE}, 1);
    CondE = 4'b1010;
    fall();
    chk("ge_memwr", {31'd0, MemWriteM}, 0);
    chk("ge_wdata", WriteDataM, 32'hDEADBEEF);
    chk("ge_memtoreg", {31'd0, MemtoRegM}, 1);
    idle(); FlagWriteE = 2'b11; ALUFlagsE = 4'b0000;
    fall();
    chk("clr_flags", {28'd0, Flags}, 0);
    idle(); RegWriteE = 1; CondE = 4'b0000; FlagWriteE = 2'b11; ALUFlagsE = 4'b1111;
    fall();
    chk("fail_flags", {28'd0, Flags}, 0);
    chk("fail_regwr", {31'd0, RegWriteM}, 0);
    idle(); FlagWriteE = 2'b01; ALUFlagsE = 4'b1111;
    fall();
    chk("cv_flags", {28'd0, Flags}, 4'b0011);
    idle(); FlagWriteE = 2'b10; ALUFlagsE = 4'b1000;
    fall();
    chk("nz_flags", {28'd0, Flags}, 4'b1011);
    CondE = 4'b1000;
    #1 chk("hi_condex", {31'd0, CondExE}, 1);
    CondE = 4'b1100;
    #1 chk("gt_condex", {31'd0, CondExE}, 1);
    CondE = 4'b1101;
    #1 chk("le_condex", {31'd0, CondExE}, 0);
    CondE = 4'b1111;
    #1 chk("nv_condex", {31'd0, CondExE}, 1);
    idle(); RegWriteE = 1; MemWriteE = 1; ALUResultE = 32'h55; WriteDataE = 32'h66; WA3E = 7;
    fall();
    stallM = 1;
    for (int i = 0; i < 3; i++) begin
      FlagWriteE = 2'b11; ALUFlagsE = 4'b0101; ALUResultE = 32'h100 + i; WriteDataE = i; WA3E = 4'(i); RegWriteE = 0;
      fall();
      chk("stall_regwr", {31'd0, RegWriteM}, 1);
      chk("stall_memwr", {31'd0, MemWriteM}, 1);
      chk("stall_alu", ALUResultM, 32'h55);
      chk("stall_wa3", {28'd0, WA3M}, 7);
      chk("stall_flags", {28'd0, Flags}, 4'b1011);
    end
    stallM = 0; flushM = 1; BranchE = 1; CondE = 4'hE; RegWriteE = 1; MemWriteE = 1;
    #1 chk("flush_pcsrc", {31'd0, PCSrcE}, 0);
    fall();
    chk("flush_regwr", {31'd0, RegWriteM}, 0);
    chk("flush_memwr", {31'd0, MemWriteM}, 0);
    chk("flush_alu", ALUResultM, 0);
    chk("flush_wdata", WriteDataM, 0);
    chk("flush_flags", {28'd0, Flags}, 4'b1011);
    flushM = 0; idle(); ALUResultE = 32'h77; RegWriteE = 1;
    fall();
    chk("load_alu", ALUResultM, 32'h77);
    stallM = 1; flushM = 1; ALUResultE = 32'h88;
    fall();
    chk("both_alu", ALUResultM, 32'h77);
    chk("both_regwr", {31'd0, RegWriteM}, 1);
    stallM = 0; flushM = 0;
    idle(); RegWriteE = 1; MemWriteE = 1; MemtoRegE = 1; ALUResultE = 32'h99; WriteDataE = 32'hAA; WA3E = 9;
    fall();
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst_regwr", {31'd0, RegWriteM}, 0);
    chk("arst_memwr", {31'd0, MemWriteM}, 0);
    chk("arst_memtoreg", {31'd0, MemtoRegM}, 0);
    chk("arst_alu", ALUResultM, 0);
    chk("arst_wdata", WriteDataM, 0);
    chk("arst_wa3", {28'd0, WA3M}, 0);
    chk("arst_flags", {28'd0, Flags}, 0);
    #5 rst = 0;
    idle();
`ifdef EX_COND_SQUASH_CNT_EN
    chk("sq_rst", squash_cnt, 0);
    RegWriteE = 1; CondE = 4'b0000;
    for (int i = 0; i < 5; i++) fall();
    chk("sq_five", squash_cnt, 5);
    idle();
    fall();
    chk("sq_hold", squash_cnt, 5);
    rst = 1;
    #1 chk("sq_clear", squash_cnt, 0);
    rst = 0;
`endif
    fall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
